multicycle_control: RTL



---
 rtl/mcu_pkg.sv | 47 ++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/mc_wait_timer.sv | 31 +++
 rtl/multicycle_control.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller:
// FSM states, opcodes and datapath mux/ALU select codes.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) ||
           (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in,
// datapath control strobes and debug state out.
interface multicycle_control_if;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal_op;
  logic       bus_error;
  logic [3:0] state;

  modport master (
    input  Op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead,
    output MemWrite, IRWrite, MemtoReg, RegDst,
    output RegWrite, ALUSrcA, ALUSrcB, ALUOp,
    output PCSource, illegal_op, bus_error, state
  );

  modport slave (
    output Op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead,
    input  MemWrite, IRWrite, MemtoReg, RegDst,
    input  RegWrite, ALUSrcA, ALUSrcB, ALUOp,
    input  PCSource, illegal_op, bus_error, state
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait counter: clear wins over enable; expired flags
// the last allowed wait cycle (count == MAX_WAIT-1).
module mc_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath with
// memory-timeout and illegal-opcode traps.
import mcu_pkg::*;

module multicycle_control #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  state_e state_q, state_d;
  logic   cause_q, cause_d;
  logic   expired;
  logic   rdy;

  assign rdy = bus.mem_ready;

  // Any state change restarts the count for the next wait state.
  mc_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_d != state_q),
    .en      (is_wait_state(state_q) && !rdy),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (rdy) state_d = S_DECODE;
        else if (expired) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (bus.Op == OP_RTYPE): state_d = S_EXECUTE;
          (bus.Op == OP_LW),
          (bus.Op == OP_SW):    state_d = S_MEM_ADDR;
          (bus.Op == OP_BEQ):   state_d = S_BRANCH;
          (bus.Op == OP_J):     state_d = S_JUMP;
          (bus.Op == OP_ADDI):  state_d = S_ADDI_EXEC;
          default: begin
            state_d = S_TRAP;
            cause_d = 1'b0;
          end
        endcase
      end
      S_MEM_ADDR:
        state_d = (bus.Op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (rdy) state_d = S_MEM_WB;
        else if (expired) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end
      end
      S_MEM_WRITE: begin
        if (rdy) state_d = S_FETCH;
        else if (expired) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end
      end
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH,
      S_JUMP, S_ADDI_WB, S_TRAP:
        state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SRCB_REG;
    bus.ALUOp       = ALUOP_ADD;
    bus.PCSource    = PCSRC_ALU;
    bus.illegal_op  = 1'b0;
    bus.bus_error   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.IRWrite = rdy;
        bus.PCWrite = rdy;
      end
      S_DECODE: bus.ALUSrcB = SRCB_IMM_SH2;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEM_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = ALUOP_SUB;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = PCSRC_JUMP;
      end
      S_ADDI_WB: bus.RegWrite = 1'b1;
      S_TRAP: begin
        bus.illegal_op = !cause_q;
        bus.bus_error  = cause_q;
      end
      default: ;
    endcase
  end

  assign bus.state = state_q;

endmodule
